cpu_mem_bus_sequencer: RTL
==========================

Name: cpu_mem_bus_sequencer

Overview:
Controller that sequences 32-bit CPU memory transactions over the chip's 8-bit pin bus.
- Accepts one read or write request from the CPU core.
- Serialises address and write data out one byte per cycle, little-endian.
- Collects four read-data bytes under an external valid strobe, with a timeout.
- Returns a one-cycle completion pulse to the CPU.
- Sits between the cpu core and the top-level uo_out/uio_out/uio_in/uio_oe pins, replacing ad-hoc counter slicing in the top wrapper.

Parameters:
- TIMEOUT, 16: consecutive read-phase cycles without pin_valid before the transaction aborts with an error (legal range 2..255).
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- cpu_req  in  1  transaction request, sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read; latched with cpu_req.
- cpu_addr  in  32  byte address; latched with cpu_req.
- cpu_wdata  in  32  write data; latched with cpu_req.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  high with cpu_ready when a read timed out.
- cpu_rdata  out  32  read result; valid while cpu_ready = 1, held until the next completion.
- cpu_busy  out  1  high from the cycle after acceptance through DONE.
- pin_out  out  8  outgoing byte (address or write data).
- pin_strobe  out  1  pin_out carries a valid byte this cycle.
- pin_sync  out  1  high only on address byte 0 (frame start).
- pin_we  out  1  latched cpu_we, held for the whole transaction.
- pin_oe  out  1  1 while driving (ADDR/WDATA), 0 otherwise; drives uio_oe.
- pin_in  in  8  incoming read byte.
- pin_valid  in  1  pin_in valid; honoured only in RDATA.

Behaviour:
- All outputs are registered.
- Reset (async, rst_n = 0):
  - state = IDLE, byte index = 0, timeout counter = 0.
  - Every output = 0, including cpu_rdata.
  - Reset asserted mid-transaction aborts it with no cpu_ready pulse.
  - First acceptance is possible on the first rising edge after release.
- States: IDLE, ADDR, WDATA, RDATA, DONE. A 2-bit byte index runs 0..3.
- IDLE:
  - On cpu_req = 1: latch addr/wdata/we, set byte index = 0, go to ADDR.
  - cpu_busy rises in the next cycle.
  - CPU inputs may change after the acceptance cycle.
- ADDR (4 cycles):
  - pin_out = addr[8*i+7 : 8*i], pin_strobe = 1, pin_oe = 1.
  - pin_sync = 1 only for i = 0.
  - After i = 3: go to WDATA if we, else RDATA; byte index resets to 0.
- WDATA (4 cycles): pin_out = wdata bytes 0..3, pin_strobe = 1, pin_oe = 1; then DONE.
- RDATA:
  - pin_oe = 0, pin_strobe = 0, pin_out = 0.
  - Each cycle with pin_valid = 1: rdata[8*i+7 : 8*i] = pin_in, i++, timeout counter cleared.
  - After byte 3 is captured: go to DONE.
  - Each cycle with pin_valid = 0: counter++. When the counter reaches TIMEOUT, go to DONE with the error flag set.
  - On timeout, uncaptured bytes read as 0x00.
- DONE (1 cycle):
  - cpu_ready = 1; cpu_err = the error flag.
  - cpu_busy stays high this cycle. Go to IDLE.
  - cpu_req is ignored in DONE. If it is still high in IDLE the following cycle, a new transaction starts (back-to-back, one idle cycle between frames).
- Latency, acceptance edge = cycle 0:
  - Write: bytes on cycles 1-8, cpu_ready on cycle 9.
  - Read with zero-gap pin_valid: address on 1-4, capture on 5-8, cpu_ready on 9.
- pin_valid outside RDATA is ignored. pin_in is never combinationally passed to cpu_rdata.
- The byte index wraps only via the state transitions; no index value above 3 is reachable.

Decomposition:
- Package cpu_bus_pkg holds:
  - State enum (IDLE/ADDR/WDATA/RDATA/DONE).
  - BYTES_PER_WORD = 4 and the byte-index width.
  - Default TIMEOUT.
- One sub-module, bus_timeout_counter:
  - Inputs: clear, enable.
  - Output: expired pulse at TIMEOUT.
  - Reset: async active-low.
- Byte selection and assembly stay in the top FSM.

Test Plan:
- Write addr 0x12345678, wdata 0xDEADBEEF:
  - pin_out 78,56,34,12,EF,BE,AD,DE on cycles 1-8, strobe high, sync only on cycle 1, oe high 1-8.
  - cpu_ready = 1 on cycle 9, err = 0.
- Read addr 0x000000A4, pin_valid high from cycle 5 with pin_in 11,22,33,44:
  - cpu_rdata = 0x44332211 with cpu_ready on cycle 9; pin_oe = 0 cycles 5-9.
- Read with gaps, valid bytes separated by 3 idle cycles each (below TIMEOUT):
  - rdata is assembled correctly, err = 0, ready one cycle after the 4th byte.
- Timeout, TIMEOUT = 16, bytes AA,BB then silence:
  - ready + err exactly 17 cycles after the BB capture (16 counted idle cycles, then DONE).
  - cpu_rdata = 0x0000BBAA.
- Reset mid-write (rst_n low at cycle 6):
  - All outputs 0 immediately (async), no ready pulse.
  - After release, a new read completes normally.
- Back-to-back: cpu_req held high across two writes:
  - Second frame's pin_sync on cycle 11; two ready pulses (cycles 9 and 19); changed CPU inputs after acceptance do not affect frame 1.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU-to-pin-bus transaction sequencer.
// Holds the FSM state encoding, word/byte geometry and the default read timeout.
package cpu_bus_pkg;

    localparam int BYTES_PER_WORD  = 4;
    localparam int IDX_W           = $clog2(BYTES_PER_WORD);
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } bus_state_e;

    typedef logic [IDX_W-1:0] byte_idx_t;

    // Little-endian byte lane select: lane 0 is bits [7:0].
    function automatic logic [7:0] word_byte(input logic [31:0] word, input byte_idx_t idx);
        return word[8*idx +: 8];
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts consecutive idle read cycles; pulses expired on the cycle the count reaches TIMEOUT.
// The counter restarts from zero after expiring or whenever clear is asserted.
module bus_timeout_counter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // The current idle cycle is the TIMEOUT-th one when TIMEOUT-1 have already been counted.
    assign expired = enable && (cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: sequential state is assigned with non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || expired) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_mem_bus_sequencer.sv
// Sequences one 32-bit CPU read/write over the 8-bit pin bus: address and write data go out
// little-endian one byte per cycle, read bytes are gathered under pin_valid with a timeout.
module cpu_mem_bus_sequencer
    import cpu_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        cpu_busy,
    output logic [7:0]  pin_out,
    output logic        pin_strobe,
    output logic        pin_sync,
    output logic        pin_we,
    output logic        pin_oe,
    input  logic [7:0]  pin_in,
    input  logic        pin_valid
);

    bus_state_e  state, state_nxt;
    byte_idx_t   idx, idx_nxt;
    logic        we_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        last_byte;
    logic        in_rdata;
    logic        to_expired;

    assign last_byte = (idx == byte_idx_t'(BYTES_PER_WORD - 1));
    assign in_rdata  = (state == ST_RDATA);

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_rdata || pin_valid),
        .enable  (in_rdata && !pin_valid),
        .expired (to_expired)
    );

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_nxt = ST_ADDR;
                    idx_nxt   = '0;
                end
            end
            ST_ADDR: begin
                if (last_byte) begin
                    state_nxt = we_q ? ST_WDATA : ST_RDATA;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + byte_idx_t'(1);
                end
            end
            ST_WDATA: begin
                if (last_byte) begin
                    state_nxt = ST_DONE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + byte_idx_t'(1);
                end
            end
            ST_RDATA: begin
                if (pin_valid) begin
                    if (last_byte) begin
                        state_nxt = ST_DONE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + byte_idx_t'(1);
                    end
                end else if (to_expired) begin
                    state_nxt = ST_DONE;
                    idx_nxt   = '0;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            // Assembly register starts at zero so bytes missed by a timeout read back as 0x00.
            if (state == ST_IDLE && cpu_req) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (in_rdata && pin_valid) begin
                rdata_q[8*idx +: 8] <= pin_in;
            end
            if (in_rdata && !pin_valid && to_expired) begin
                err_q <= 1'b1;
            end
        end
    end

    // Output stage: every pin and CPU output is a flop driven from the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ready  <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= '0;
            cpu_busy   <= 1'b0;
            pin_out    <= '0;
            pin_strobe <= 1'b0;
            pin_sync   <= 1'b0;
            pin_we     <= 1'b0;
            pin_oe     <= 1'b0;
        end else begin
            pin_strobe <= state inside {ST_ADDR, ST_WDATA};
            pin_oe     <= state inside {ST_ADDR, ST_WDATA};
            pin_sync   <= (state == ST_ADDR) && (idx == '0);
            pin_we     <= (state != ST_IDLE) && we_q;
            cpu_busy   <= (state != ST_IDLE);
            cpu_ready  <= (state == ST_DONE);
            cpu_err    <= (state == ST_DONE) && err_q;
            case (state)
                ST_ADDR:  pin_out <= word_byte(addr_q, idx);
                ST_WDATA: pin_out <= word_byte(wdata_q, idx);
                default:  pin_out <= 8'h00;
            endcase
            if (state == ST_DONE) begin
                cpu_rdata <= rdata_q;
            end
        end
    end

endmodule
